// File: rtl/motor_seq_pkg.sv
// Shared types, direction codes and the direction decoder for the motor sequencer.
package motor_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2,
    ST_BRAKE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_SLOW = 2'd1,
    SEL_FULL = 2'd2
  } sel_t;

  typedef struct packed {
    logic stop_req;
    sel_t l_sel;
    sel_t r_sel;
  } dec_t;

  localparam logic [3:0] DIR_FWD   = 4'b0000;
  localparam logic [3:0] DIR_LEFT  = 4'b0101;
  localparam logic [3:0] DIR_RIGHT = 4'b1001;
  localparam logic [3:0] DIR_STOP  = 4'b1111;

  // Unlisted codes fall into stop so a glitched code can never drive the wheels.
  function automatic dec_t decode_dir(input logic [3:0] dir);
    dec_t d;
    d.stop_req = 1'b1;
    d.l_sel    = SEL_ZERO;
    d.r_sel    = SEL_ZERO;
    case (dir)
      DIR_FWD:   begin d.stop_req = 1'b0; d.l_sel = SEL_FULL; d.r_sel = SEL_FULL; end
      DIR_LEFT:  begin d.stop_req = 1'b0; d.l_sel = SEL_SLOW; d.r_sel = SEL_FULL; end
      DIR_RIGHT: begin d.stop_req = 1'b0; d.l_sel = SEL_FULL; d.r_sel = SEL_SLOW; end
      default:   d.stop_req = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/motor_sequencer_pwm_channel.sv
// One wheel channel: duty register loaded on period boundaries, registered PWM compare.
// MOTOR_RAMP_EN: duty slews toward target by at most RAMP_STEP per period.
module pwm_channel
  import motor_seq_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8
`ifdef MOTOR_RAMP_EN
  , parameter int RAMP_STEP = 1
`endif
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_bnd,
  input  logic          i_run,
  input  logic          i_clr,
  input  logic [DW-1:0] i_tgt,
  input  logic [CW-1:0] i_cnt_nxt,
  output logic          o_pwm
);

  logic [DW-1:0] r_duty;
  logic          r_pwm;
  logic [DW-1:0] w_load;
  logic [DW-1:0] w_duty_nxt;
  logic [DW-1:0] w_cnt_ext;

`ifdef MOTOR_RAMP_EN
  localparam logic [DW-1:0] STEP_C = (RAMP_STEP >= (1 << DW)) ? {DW{1'b1}} : DW'(RAMP_STEP);
  logic          w_up;
  logic [DW-1:0] w_diff;
  logic [DW-1:0] w_mv;

  always_comb begin
    w_up   = (i_tgt > r_duty);
    w_diff = w_up ? (i_tgt - r_duty) : (r_duty - i_tgt);
    w_mv   = (w_diff > STEP_C) ? STEP_C : w_diff;
    w_load = w_up ? (r_duty + w_mv) : (r_duty - w_mv);
  end
`else
  assign w_load = i_tgt;
`endif

  always_comb begin
    w_duty_nxt = r_duty;
    if (i_clr) w_duty_nxt = '0;
    else if (i_bnd && i_run) w_duty_nxt = w_load;
  end

  // Compare against next-cycle counter and duty so the registered output lines up with pwm_cnt.
  assign w_cnt_ext = DW'(i_cnt_nxt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_duty <= w_duty_nxt;
      r_pwm  <= i_run && (w_cnt_ext < w_duty_nxt);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/motor_sequencer.sv
// Drive sequencer: direction decode, ESTOP sync, shared PWM counter, IDLE/ALIGN/RUN/BRAKE FSM.
// Optional duty ramping is compiled in with MOTOR_RAMP_EN.
module motor_sequencer
  import motor_seq_pkg::*;
#(
  parameter int PWM_PERIOD   = 250,
  parameter int FULL_DUTY    = 250,
  parameter int SLOW_DUTY    = 100,
  parameter int BRAKE_CYCLES = 1_250_000,
  parameter int RAMP_STEP    = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] DIR,
  input  logic       ESTOP,
  output logic       L_PWM,
  output logic       R_PWM,
  output logic       L_BRK,
  output logic       R_BRK,
  output logic [1:0] STATE
);

  localparam int CW = $clog2(PWM_PERIOD);
  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int BW = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);
  localparam logic [BW-1:0] BRK_LAST = BW'(BRAKE_CYCLES - 1);
  localparam logic [DW-1:0] FULL_D   = DW'(FULL_DUTY);
  localparam logic [DW-1:0] SLOW_D   = DW'(SLOW_DUTY);

  if (PWM_PERIOD < 2 || FULL_DUTY > PWM_PERIOD || SLOW_DUTY > FULL_DUTY ||
      BRAKE_CYCLES < 1 || RAMP_STEP < 1) begin : g_bad_params
    $error("motor_sequencer: illegal parameter combination");
  end

  function automatic logic [DW-1:0] sel_duty(input sel_t s);
    case (s)
      SEL_FULL: return FULL_D;
      SEL_SLOW: return SLOW_D;
      default:  return '0;
    endcase
  endfunction

  logic [3:0]    r_dir_q;
  logic          r_estop_m;
  logic          r_estop_s;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_brk_cnt;
  logic          r_brk;
  state_t        r_state;

  dec_t          w_dec;
  logic          w_stop;
  logic          w_bnd;
  logic [CW-1:0] w_cnt_nxt;
  state_t        w_state_nxt;
  logic          w_run_nxt;
  logic          w_clr_nxt;
  logic          w_brk_nxt;
  logic          w_l_pwm;
  logic          w_r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir_q   <= DIR_STOP;
      r_estop_m <= 1'b0;
      r_estop_s <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_dir_q   <= DIR;
      r_estop_m <= ESTOP;
      r_estop_s <= r_estop_m;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign w_dec     = decode_dir(r_dir_q);
  assign w_stop    = w_dec.stop_req | r_estop_s;
  assign w_bnd     = (r_cnt == CNT_LAST);
  assign w_cnt_nxt = w_bnd ? '0 : r_cnt + 1'b1;

  // Stop/ESTOP outranks a coincident boundary, so no duty load happens on the way into BRAKE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_stop) w_state_nxt = ST_ALIGN;
      ST_ALIGN: if (w_stop) w_state_nxt = ST_BRAKE;
                else if (w_bnd) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_stop) w_state_nxt = ST_BRAKE;
      ST_BRAKE: if (r_brk_cnt == BRK_LAST) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    w_run_nxt = (w_state_nxt == ST_RUN);
    w_clr_nxt = (w_state_nxt == ST_BRAKE) || (w_state_nxt == ST_IDLE);
    w_brk_nxt = w_clr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_brk     <= 1'b1;
      r_brk_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_brk   <= w_brk_nxt;
      if (r_state != ST_BRAKE) r_brk_cnt <= '0;
      else if (r_brk_cnt != BRK_LAST) r_brk_cnt <= r_brk_cnt + 1'b1;
    end
  end

  pwm_channel #(
    .DW(DW), .CW(CW)
`ifdef MOTOR_RAMP_EN
    , .RAMP_STEP(RAMP_STEP)
`endif
  ) u_left (
    .i_clk(clk), .i_rst_n(rst_n), .i_bnd(w_bnd), .i_run(w_run_nxt), .i_clr(w_clr_nxt),
    .i_tgt(sel_duty(w_dec.l_sel)), .i_cnt_nxt(w_cnt_nxt), .o_pwm(w_l_pwm)
  );

  pwm_channel #(
    .DW(DW), .CW(CW)
`ifdef MOTOR_RAMP_EN
    , .RAMP_STEP(RAMP_STEP)
`endif
  ) u_right (
    .i_clk(clk), .i_rst_n(rst_n), .i_bnd(w_bnd), .i_run(w_run_nxt), .i_clr(w_clr_nxt),
    .i_tgt(sel_duty(w_dec.r_sel)), .i_cnt_nxt(w_cnt_nxt), .o_pwm(w_r_pwm)
  );

  assign L_PWM = w_l_pwm;
  assign R_PWM = w_r_pwm;
  assign L_BRK = r_brk;
  assign R_BRK = r_brk;
  assign STATE = r_state;

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer with a queue of expected results checked as outputs appear.
module tb_motor_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] DIR;
  logic       ESTOP;
  logic       L_PWM, R_PWM, L_BRK, R_BRK;
  logic [1:0] STATE;

  motor_sequencer #(
    .PWM_PERIOD(10), .FULL_DUTY(10), .SLOW_DUTY(4), .BRAKE_CYCLES(5), .RAMP_STEP(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .DIR(DIR), .ESTOP(ESTOP),
    .L_PWM(L_PWM), .R_PWM(R_PWM), .L_BRK(L_BRK), .R_BRK(R_BRK), .STATE(STATE)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %0d expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // Next per-period duty given the current one and the decoded target.
  function automatic int nd(input int cur, input int tgt);
`ifdef MOTOR_RAMP_EN
    if (tgt > cur) return (tgt - cur > 3) ? cur + 3 : tgt;
    return (cur - tgt > 3) ? cur - 3 : tgt;
`else
    return tgt;
`endif
  endfunction

  task automatic measure(input int n, output int lh, output int rh, output int bh);
    lh = 0; rh = 0; bh = 0;
    for (int i = 0; i < n; i++) begin
      lh += int'(L_PWM);
      rh += int'(R_PWM);
      bh += int'(L_BRK) + int'(R_BRK);
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int max_cyc);
    int n;
    n = 0;
    while (STATE !== st && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lh, rh, bh, n, bad, l_d, r_d;
    DIR   = 4'b1111;
    ESTOP = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    expect_v("rst_L_PWM", 0); check_v(L_PWM);
    expect_v("rst_R_PWM", 0); check_v(R_PWM);
    expect_v("rst_L_BRK", 1); check_v(L_BRK);
    expect_v("rst_R_BRK", 1); check_v(R_BRK);
    expect_v("rst_STATE", 0); check_v(STATE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    DIR   = 4'b0000;

    // Forward start: one edge into dir_q, second edge reaches the FSM.
    @(negedge clk);
    expect_v("fwd_idle_1edge", 0); check_v(STATE);
    @(negedge clk);
    expect_v("fwd_align_2edge", 1); check_v(STATE);
    expect_v("fwd_align_brk", 0); check_v(L_BRK);
    n = 0; bad = 0;
    while (STATE === 2'd1 && n < 30) begin
      bad += int'(L_PWM) + int'(R_PWM);
      n++;
      @(negedge clk);
    end
    expect_v("align_cycles", 8); check_v(n);
    expect_v("align_pwm_low", 0); check_v(bad);
    expect_v("fwd_run", 2); check_v(STATE);
    l_d = 0; r_d = 0;
    for (int p = 0; p < 5; p++) begin
      l_d = nd(l_d, 10);
      r_d = nd(r_d, 10);
      expect_v($sformatf("fwd_p%0d_L", p), l_d);
      expect_v($sformatf("fwd_p%0d_R", p), r_d);
      expect_v($sformatf("fwd_p%0d_brk", p), 0);
      measure(10, lh, rh, bh);
      check_v(lh); check_v(rh); check_v(bh);
    end

    // Veer left mid-period: current period must finish at the old duty.
    repeat (3) @(negedge clk);
    DIR = 4'b0101;
    expect_v("veer_tail_L", 7);
    expect_v("veer_tail_R", 7);
    measure(7, lh, rh, bh);
    check_v(lh); check_v(rh);
    l_d = nd(l_d, 4);
    r_d = nd(r_d, 10);
    expect_v("veer_L", l_d);
    expect_v("veer_R", r_d);
    measure(10, lh, rh, bh);
    check_v(lh); check_v(rh);

    // Stop in RUN: BRAKE two edges later, exactly five cycles long.
    DIR = 4'b1111;
    @(negedge clk);
    expect_v("stop_run_1edge", 2); check_v(STATE);
    @(negedge clk);
    expect_v("stop_brake", 3); check_v(STATE);
    expect_v("stop_pwm", 0); check_v(L_PWM | R_PWM);
    n = 0; bad = 0;
    while (STATE === 2'd3 && n < 20) begin
      bad += int'(L_PWM) + int'(R_PWM) + int'(!L_BRK) + int'(!R_BRK);
      n++;
      @(negedge clk);
    end
    expect_v("brake_len", 5); check_v(n);
    expect_v("brake_outputs", 0); check_v(bad);
    expect_v("stop_idle", 0); check_v(STATE);
    repeat (3) @(negedge clk);
    expect_v("stop_idle_hold", 0); check_v(STATE);
    expect_v("stop_idle_brk", 1); check_v(R_BRK);

    // Veer right run, then ESTOP.
    DIR = 4'b1001;
    wait_state(2'd2, 40);
    expect_v("right_run", 2); check_v(STATE);
    expect_v("right_L", nd(0, 10));
    expect_v("right_R", nd(0, 4));
    measure(10, lh, rh, bh);
    check_v(lh); check_v(rh);
    ESTOP = 1'b1;
    @(negedge clk);
    @(negedge clk);
    expect_v("estop_2edge_run", 2); check_v(STATE);
    @(negedge clk);
    expect_v("estop_3edge_brake", 3); check_v(STATE);
    expect_v("estop_pwm", 0); check_v(L_PWM | R_PWM);
    expect_v("estop_brk", 1); check_v(L_BRK & R_BRK);
    n = 0;
    while (STATE === 2'd3 && n < 20) begin
      n++;
      @(negedge clk);
    end
    expect_v("estop_brake_len", 5); check_v(n);
    repeat (10) @(negedge clk);
    expect_v("estop_hold_idle", 0); check_v(STATE);
    ESTOP = 1'b0;
    wait_state(2'd1, 20);
    expect_v("estop_rel_align", 1); check_v(STATE);
    wait_state(2'd2, 20);
    expect_v("estop_rel_run", 2); check_v(STATE);
    expect_v("estop_rel_L", nd(0, 10));
    expect_v("estop_rel_R", nd(0, 4));
    measure(10, lh, rh, bh);
    check_v(lh); check_v(rh);

    // Asynchronous reset mid-RUN.
    expect_v("prerst_L_PWM", 1); check_v(L_PWM);
    #2 rst_n = 1'b0;
    #1;
    expect_v("arst_L_PWM", 0); check_v(L_PWM);
    expect_v("arst_R_PWM", 0); check_v(R_PWM);
    expect_v("arst_BRK", 1); check_v(L_BRK & R_BRK);
    expect_v("arst_STATE", 0); check_v(STATE);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_sequencer.md
# motor_sequencer

Drive sequencer between the direction-control stage and the two H-bridge channels. It takes the debounced 4-bit direction code and produces per-wheel PWM and brake signals. It enforces a brake dwell before any restart and responds to an emergency-stop input. PWM duty changes only at PWM period boundaries, so the bridges never see a truncated pulse.

## Interface
- PWM_PERIOD, 250: PWM period in clk cycles (100 kHz at 25 MHz); must be ≥ 2.
- FULL_DUTY, 250: high cycles per period at full speed; ≤ PWM_PERIOD.
- SLOW_DUTY, 100: high cycles per period for the inner wheel while veering; ≤ FULL_DUTY.
- BRAKE_CYCLES, 1_250_000: brake dwell in clk cycles (50 ms); ≥ 1.
- RAMP_STEP, 25: maximum duty change per period when ramping is compiled in; ≥ 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- DIR  in  4  direction code: 0000 forward, 0101 veer left, 1001 veer right, 1111 stop. Any other code is treated as stop.
- ESTOP  in  1  emergency stop, asynchronous to clk, active high.
- L_PWM, R_PWM  out  1  wheel PWM, registered.
- L_BRK, R_BRK  out  1  wheel brake enable, registered, active high.
- STATE  out  2  FSM state for debug: 0 IDLE, 1 ALIGN, 2 RUN, 3 BRAKE.

## Operation
- Input stage:
  - DIR is registered into dir_q every cycle.
  - ESTOP passes through a 2-flop synchronizer to give estop_s.
  - dir_q decodes to target duties (l_tgt, r_tgt):
    - forward: FULL/FULL
    - veer left: SLOW/FULL
    - veer right: FULL/SLOW
    - stop: 0/0 with stop_req = 1
- PWM counter:
  - pwm_cnt is free-running over 0..PWM_PERIOD-1 and wraps to 0.
  - bnd = (pwm_cnt == PWM_PERIOD-1).
  - Counter width is $clog2(PWM_PERIOD); duty width is $clog2(PWM_PERIOD+1).
- Channel output: PWM = (pwm_cnt < duty) while in RUN, 0 in every other state.
- Duty update: on bnd in RUN, duty is loaded from the target. A DIR change between non-stop codes never truncates or extends the current period.
- FSM states and transitions:
  - IDLE: both brakes = 1, both PWMs = 0, duties = 0. Go to ALIGN when stop_req = 0 and estop_s = 0.
  - ALIGN: brakes = 0, PWMs = 0. On bnd, load the duties and go to RUN, so the first pulse starts at pwm_cnt = 0. If stop_req or estop_s asserts, go to BRAKE.
  - RUN: brakes = 0. Go to BRAKE immediately (no boundary wait) when stop_req = 1 or estop_s = 1.
  - BRAKE: brakes = 1, PWMs forced 0, duties cleared to 0, brk_cnt counts up from 0.
    - At brk_cnt == BRAKE_CYCLES-1, go to IDLE.
    - Re-entering conditions during BRAKE do not restart the count.
    - brk_cnt is cleared on entry.
- Simultaneous events: stop_req/estop_s and bnd in the same cycle means BRAKE wins and no duty load happens. ESTOP held high keeps the FSM in IDLE after BRAKE.
- Reset mid-operation: all state returns to reset values asynchronously; brakes are asserted immediately.

## Timing
- Reset values:
  - L_PWM = R_PWM = 0, L_BRK = R_BRK = 1, STATE = 0.
  - pwm_cnt = 0, brk_cnt = 0, duties = 0.
  - dir_q = 1111, synchronizer flops = 0.
- DIR to FSM reaction: 2 edges (dir_q, then state/output register).
- ESTOP to PWM low and brake high: 3 edges after ESTOP is first sampled high.
- Target change in RUN: takes effect on the first bnd after dir_q updates; the new duty is visible from pwm_cnt = 0.
- Minimum stop-to-restart time: BRAKE_CYCLES + 1 (IDLE) + up to PWM_PERIOD (ALIGN).

## Configuration
- MOTOR_RAMP_EN defined:
  - On each bnd in RUN, each duty moves toward its target by min(RAMP_STEP, |target − duty|).
  - Entry from ALIGN starts from duty 0 and ramps up.
  - BRAKE still clears duties immediately.
- MOTOR_RAMP_EN undefined: duty jumps directly to target on bnd; the RAMP_STEP parameter is accepted but unused.

## Structure
- Package motor_seq_pkg holds:
  - state enum (IDLE, ALIGN, RUN, BRAKE)
  - DIR code constants (DIR_FWD, DIR_LEFT, DIR_RIGHT, DIR_STOP)
  - a decode function returning {stop_req, l_sel, r_sel}
- Sub-module pwm_channel, instantiated twice. It contains the duty register, the optional ramp logic, and the compare against the shared pwm_cnt. Its inputs are bnd, run, clr and target.

## Test plan
Use PWM_PERIOD=10, FULL_DUTY=10, SLOW_DUTY=4, BRAKE_CYCLES=5, RAMP_STEP=3.
- Reset then DIR=0000: PWMs stay 0 until the first pwm_cnt=0 after ALIGN, then L_PWM and R_PWM are high for 10 of every 10 cycles; brakes are 0.
- DIR 0000→0101 mid-period: the current period finishes at full duty; from the next period L_PWM is high for 4 cycles and R_PWM for 10.
- DIR→1111 in RUN: 2 edges later PWMs = 0 and brakes = 1 for exactly 5 cycles in BRAKE, then IDLE with brakes held at 1.
- ESTOP pulsed high while DIR=1001: BRAKE is entered 3 edges later. With ESTOP still high after 5 cycles the FSM stays in IDLE. After release it passes through ALIGN to RUN with L=10/R=4.
- rst_n low mid-RUN: outputs go to the reset values immediately without waiting for clk.
- MOTOR_RAMP_EN with DIR=0000 from IDLE: duty per period is 3, 6, 9, 10, 10.
